// File: rtl/main_memory_pkg.sv
// Shared widths, default sizing and operation encoding for the line-oriented main memory.
package main_memory_pkg;

  localparam int MEMORY_ADDRESS_SIZE = 32;
  localparam int CACHE_LINE_SIZE = 128;
  localparam int DEFAULT_MEMORY_LATENCY_CYCLES = 5;
  localparam int DEFAULT_MEMORY_DEPTH_LINES = 1024;

  // Wide enough for the largest legal latency of 15 cycles.
  localparam int COUNTER_WIDTH = 4;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_e;

endpackage

// File: rtl/main_memory_latency_counter.sv
// Down-counter timing the BUSY phase of an access: loadable, decrements while enabled, flags zero.
module latency_counter
  import main_memory_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic [COUNTER_WIDTH-1:0] load_value,
  input  logic                     dec,
  output logic                     zero
);

  logic [COUNTER_WIDTH-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/main_memory.sv
// Single-port line memory serving one cache request at a time with a fixed access latency
// and a READY phase that holds the result until the requester releases it.
module main_memory
  import main_memory_pkg::*;
#(
  parameter int MEMORY_LATENCY_CYCLES = DEFAULT_MEMORY_LATENCY_CYCLES,
  parameter int MEMORY_DEPTH_LINES    = DEFAULT_MEMORY_DEPTH_LINES
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           op,
  input  logic                           op_init,
  input  logic                           op_done,
  input  logic [MEMORY_ADDRESS_SIZE-1:0] address,
  input  logic [CACHE_LINE_SIZE-1:0]     data_in,
  output logic [CACHE_LINE_SIZE-1:0]     data_out,
  output logic                           data_ready,
  output logic                           memory_in_use,
  output logic [1:0]                     fsm_state
);

  localparam int INDEX_WIDTH = $clog2(MEMORY_DEPTH_LINES);
  localparam logic [COUNTER_WIDTH-1:0] LOAD_VALUE = COUNTER_WIDTH'(MEMORY_LATENCY_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                     state;
  mem_op_e                    op_q;
  logic [INDEX_WIDTH-1:0]     index_q;
  logic [CACHE_LINE_SIZE-1:0] line_q;
  logic                       count_zero;
  logic                       count_load;
  logic                       count_dec;
  logic                       array_write;
  logic                       unused_address;

  // Contents start at zero and survive reset; only completed writes change them.
  logic [CACHE_LINE_SIZE-1:0] lines [MEMORY_DEPTH_LINES] = '{default: '0};

  // Handshake: a request is enable=1 sampled in IDLE; enable must stay high through BUSY
  // (dropping it aborts), and the READY result is released by op_done=1 or enable=0.
  assign count_load  = (state == IDLE) && enable;
  assign count_dec   = (state == BUSY) && enable && !count_zero;
  assign array_write = (state == BUSY) && enable && count_zero && (op_q == OP_WRITE);
  assign fsm_state   = state;

  // Offset within the line and bits above the array size do not select anything.
  assign unused_address = ^{address[3:0], address[MEMORY_ADDRESS_SIZE-1:INDEX_WIDTH+4]};

  latency_counter u_latency_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (count_load),
    .load_value (LOAD_VALUE),
    .dec        (count_dec),
    .zero       (count_zero)
  );

  always_ff @(posedge clk) begin
    if (array_write) begin
      lines[index_q] <= line_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      data_ready    <= 1'b0;
      memory_in_use <= 1'b0;
      data_out      <= '0;
      op_q          <= OP_READ;
      index_q       <= '0;
      line_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state         <= BUSY;
            op_q          <= mem_op_e'(op);
            index_q       <= address[INDEX_WIDTH+3:4];
            line_q        <= data_in;
            memory_in_use <= 1'b1;
          end else begin
            memory_in_use <= op_init;
          end
        end
        BUSY: begin
          if (!enable) begin
            state         <= IDLE;
            memory_in_use <= op_init;
          end else if (count_zero) begin
            state      <= READY;
            data_ready <= 1'b1;
            if (op_q == OP_READ) begin
              data_out <= lines[index_q];
            end
          end
        end
        READY: begin
          // op_done and a dropped enable together count as a single release.
          if (op_done || !enable) begin
            state         <= IDLE;
            data_ready    <= 1'b0;
            memory_in_use <= op_init;
          end
        end
        default: begin
          state         <= IDLE;
          data_ready    <= 1'b0;
          memory_in_use <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory.sv
// Randomised and directed bench for main_memory checked against a line-array model.
module tb_main_memory;

  localparam int LAT   = 5;
  localparam int DEPTH = 1024;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         op;
  logic         op_init;
  logic         op_done;
  logic [31:0]  address;
  logic [127:0] data_in;
  logic [127:0] data_out;
  logic         data_ready;
  logic         memory_in_use;
  logic [1:0]   fsm_state;

  int checks = 0;
  int errors = 0;

  logic [127:0] model_mem [DEPTH];
  logic [127:0] exp_dout;
  logic [127:0] exp_q [$];

  main_memory #(
    .MEMORY_LATENCY_CYCLES (LAT),
    .MEMORY_DEPTH_LINES    (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .op            (op),
    .op_init       (op_init),
    .op_done       (op_done),
    .address       (address),
    .data_in       (data_in),
    .data_out      (data_out),
    .data_ready    (data_ready),
    .memory_in_use (memory_in_use),
    .fsm_state     (fsm_state)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 16) % DEPTH);
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Driver: present a request and wait for data_ready; lat is the number of posedges after
  // the acceptance edge (-1 on timeout). Request inputs are scrambled while the access runs.
  task automatic start_access(input logic wr, input logic [31:0] addr, input logic [127:0] wdata,
                              output int lat, output bit in_use_ok);
    enable    = 1'b1;
    op        = wr;
    address   = addr;
    data_in   = wdata;
    lat       = -1;
    in_use_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      address = $urandom;
      op      = 1'($urandom_range(0, 1));
      data_in = rand_line();
      if (!memory_in_use) in_use_ok = 1'b0;
      if (data_ready) begin
        lat = c - 1;
        break;
      end
    end
  endtask

  // Driver: release a READY result. mode 0 = op_done with enable held, 1 = enable drop, 2 = both.
  task automatic finish_access(input int mode);
    op_done = (mode != 1);
    enable  = (mode == 0);
    @(negedge clk);
    op_done = 1'b0;
    enable  = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    enable  = 1'b0;
    op      = 1'b0;
    op_init = 1'b0;
    op_done = 1'b0;
    address = '0;
    data_in = '0;
    exp_dout = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (data_ready !== 1'b0 || memory_in_use !== 1'b0 || data_out !== 128'h0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b in_use=%b dout=%h, required 0 0 0", data_ready, memory_in_use, data_out);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int lat;
    bit ok;
    logic [127:0] line;
    line = 128'hDDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666;
    start_access(1'b1, 32'h0000_0010, line, lat, ok);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL write_latency: got %0d required %0d", lat, LAT); end
    checks++;
    if (!ok) begin errors++; $display("FAIL write_in_use: memory_in_use dropped during access, required 1"); end
    checks++;
    if (data_out !== exp_dout) begin errors++; $display("FAIL write_keeps_dout: got %h required %h", data_out, exp_dout); end
    model_mem[line_of(32'h10)] = line;
    finish_access(2);
    checks++;
    if (data_ready !== 1'b0 || memory_in_use !== 1'b0) begin
      errors++; $display("FAIL write_release: ready=%b in_use=%b required 0 0", data_ready, memory_in_use);
    end

    start_access(1'b0, 32'h0000_001C, '0, lat, ok);
    exp_dout = model_mem[line_of(32'h1C)];
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL read_latency: got %0d required %0d", lat, LAT); end
    checks++;
    if (data_out !== exp_dout) begin errors++; $display("FAIL read_same_line: got %h required %h", data_out, exp_dout); end
    finish_access(0);
    checks++;
    if (data_ready !== 1'b0 || memory_in_use !== 1'b0) begin
      errors++; $display("FAIL done_with_enable: ready=%b in_use=%b required 0 0", data_ready, memory_in_use);
    end

    start_access(1'b0, 32'h0000_4010, '0, lat, ok);
    exp_dout = model_mem[line_of(32'h4010)];
    checks++;
    if (data_out !== exp_dout) begin errors++; $display("FAIL read_wrap: got %h required %h", data_out, exp_dout); end
    finish_access(1);
  endtask

  task automatic test_hold_ready();
    int lat;
    bit ok;
    start_access(1'b0, 32'h0000_0018, '0, lat, ok);
    exp_dout = model_mem[line_of(32'h18)];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (data_ready !== 1'b1 || data_out !== exp_dout) begin
        errors++; $display("FAIL hold_ready[%0d]: ready=%b dout=%h required 1 %h", i, data_ready, data_out, exp_dout);
      end
    end
    finish_access(0);
    checks++;
    if (data_ready !== 1'b0 || memory_in_use !== 1'b0 || data_out !== exp_dout) begin
      errors++; $display("FAIL hold_release: ready=%b in_use=%b dout=%h required 0 0 %h", data_ready, memory_in_use, data_out, exp_dout);
    end
  endtask

  task automatic test_abort();
    int lat;
    bit ok;
    bit ready_seen;
    enable  = 1'b1;
    op      = 1'b1;
    address = 32'h0000_0020;
    data_in = rand_line();
    ready_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (data_ready) ready_seen = 1'b1;
    end
    enable = 1'b0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (data_ready) ready_seen = 1'b1;
    end
    checks++;
    if (ready_seen) begin errors++; $display("FAIL abort_no_ready: data_ready seen 1, required 0"); end
    checks++;
    if (memory_in_use !== 1'b0) begin errors++; $display("FAIL abort_in_use: got %b required 0", memory_in_use); end
    start_access(1'b0, 32'h0000_0020, '0, lat, ok);
    exp_dout = model_mem[line_of(32'h20)];
    checks++;
    if (data_out !== exp_dout) begin errors++; $display("FAIL abort_no_write: got %h required %h", data_out, exp_dout); end
    finish_access(1);
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    bit ok;
    start_access(1'b0, 32'h0000_0010, '0, lat, ok);
    exp_dout = model_mem[line_of(32'h10)];
    finish_access(2);
    enable  = 1'b1;
    op      = 1'b1;
    address = 32'h0000_0010;
    data_in = rand_line();
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    exp_dout = '0;
    checks++;
    if (data_ready !== 1'b0 || memory_in_use !== 1'b0 || data_out !== 128'h0) begin
      errors++; $display("FAIL reset_mid_busy: ready=%b in_use=%b dout=%h required 0 0 0", data_ready, memory_in_use, data_out);
    end
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    start_access(1'b0, 32'h0000_0010, '0, lat, ok);
    exp_dout = model_mem[line_of(32'h10)];
    checks++;
    if (lat !== LAT || data_out !== exp_dout) begin
      errors++; $display("FAIL reset_keeps_array: lat=%0d dout=%h required %0d %h", lat, data_out, LAT, exp_dout);
    end
    finish_access(1);
  endtask

  task automatic test_op_init();
    checks++;
    if (memory_in_use !== 1'b0) begin errors++; $display("FAIL op_init_before: got %b required 0", memory_in_use); end
    op_init = 1'b1;
    @(negedge clk);
    checks++;
    if (memory_in_use !== 1'b1) begin errors++; $display("FAIL op_init_set: got %b required 1", memory_in_use); end
    @(negedge clk);
    op_init = 1'b0;
    @(negedge clk);
    checks++;
    if (memory_in_use !== 1'b0) begin errors++; $display("FAIL op_init_clear: got %b required 0", memory_in_use); end
  endtask

  task automatic test_random();
    int lat;
    bit ok;
    logic wr;
    logic [31:0] addr;
    logic [127:0] wdata;
    logic [127:0] expv;
    int mode;
    for (int n = 0; n < 40; n++) begin
      wr    = 1'($urandom_range(0, 1));
      addr  = {$urandom_range(0, 65535), 16'h0} | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
      wdata = rand_line();
      op_init = 1'($urandom_range(0, 1));
      // Scoreboard entry: reads return the modelled line, writes leave data_out untouched.
      exp_q.push_back(wr ? exp_dout : model_mem[line_of(addr)]);
      start_access(wr, addr, wdata, lat, ok);
      expv = exp_q.pop_front();
      if (wr) model_mem[line_of(addr)] = wdata;
      exp_dout = expv;
      checks++;
      if (lat !== LAT || !ok) begin
        errors++; $display("FAIL rand_latency[%0d]: lat=%0d in_use_ok=%0b required %0d 1", n, lat, ok, LAT);
      end
      checks++;
      if (data_out !== expv) begin errors++; $display("FAIL rand_data[%0d]: got %h required %h", n, data_out, expv); end
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        checks++;
        if (data_ready !== 1'b1 || data_out !== expv) begin
          errors++; $display("FAIL rand_hold[%0d]: ready=%b dout=%h required 1 %h", n, data_ready, data_out, expv);
        end
      end
      mode = $urandom_range(0, 2);
      finish_access(mode);
      checks++;
      if (data_ready !== 1'b0 || memory_in_use !== op_init || data_out !== expv) begin
        errors++; $display("FAIL rand_release[%0d]: ready=%b in_use=%b dout=%h required 0 %b %h",
                           n, data_ready, memory_in_use, data_out, op_init, expv);
      end
      op_init = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold_ready();
    test_abort();
    test_reset_mid_busy();
    test_op_init();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
